// File: rtl/fpa_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder between
// NUM_REQ requesters, with an operand register stage (S1) and a result stage (S2).
module fpa_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_data,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        op_count
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    // IEEE-754 single-precision add, round-to-nearest-even, denormals kept.
    // Operands are swapped so the larger magnitude supplies sign and exponent.
    function automatic logic [31:0] fpa(input logic [31:0] a, input logic [31:0] b);
        logic        big_is_a, sub, a_nan, b_nan, a_inf, b_inf, rnd;
        logic [31:0] big, sml;
        logic [7:0]  e_l, e_s, diff, lz, sh;
        logic [4:0]  shamt;
        logic [23:0] m_l, m_s, mant;
        logic [53:0] aligned;
        logic [26:0] op_s, norm;
        logic [27:0] raw;
        logic [9:0]  exp_w;
        logic [24:0] mant25;
        a_nan    = (&a[30:23]) && (|a[22:0]);
        b_nan    = (&b[30:23]) && (|b[22:0]);
        a_inf    = (&a[30:23]) && !(|a[22:0]);
        b_inf    = (&b[30:23]) && !(|b[22:0]);
        big_is_a = a[30:0] >= b[30:0];
        big      = big_is_a ? a : b;
        sml      = big_is_a ? b : a;
        e_l      = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        e_s      = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        m_l      = {|big[30:23], big[22:0]};
        m_s      = {|sml[30:23], sml[22:0]};
        diff     = e_l - e_s;
        shamt    = (diff > 8'd31) ? 5'd31 : diff[4:0];
        // Three guard bits; everything shifted past them folds into the sticky bit.
        aligned  = {m_s, 30'd0} >> shamt;
        op_s     = {aligned[53:28], aligned[27] | (|aligned[26:0])};
        sub      = big[31] ^ sml[31];
        raw      = sub ? ({1'b0, m_l, 3'b000} - {1'b0, op_s})
                       : ({1'b0, m_l, 3'b000} + {1'b0, op_s});
        lz = 8'd27;
        for (int i = 0; i < 27; i++) begin
            if (raw[i]) lz = 8'(26 - i);
        end
        if (raw[27]) begin
            sh    = 8'd0;
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_w = {2'b00, e_l} + 10'd1;
        end else begin
            sh    = (lz < e_l - 8'd1) ? lz : e_l - 8'd1;
            norm  = raw[26:0] << sh;
            exp_w = {2'b00, e_l} - {2'b00, sh};
        end
        rnd    = norm[2] & (norm[3] | norm[1] | norm[0]);
        mant25 = {1'b0, norm[26:3]} + {24'd0, rnd};
        if (mant25[24]) begin
            mant  = mant25[24:1];
            exp_w = exp_w + 10'd1;
        end else begin
            mant  = mant25[23:0];
        end
        if (a_nan || b_nan || (a_inf && b_inf && sub)) return 32'h7FC0_0000;
        else if (a_inf)                                return a;
        else if (b_inf)                                return b;
        else if (raw == 28'd0)                         return 32'd0;
        else if (exp_w >= 10'd255)                     return {big[31], 8'hFF, 23'd0};
        else if (!mant[23])                            return {big[31], 8'd0, mant[22:0]};
        else                                           return {big[31], exp_w[7:0], mant[22:0]};
    endfunction

    logic            s1_valid, s1_load, s2_load, grant_found;
    logic [31:0]     s1_a, s1_b, fpa_sum;
    logic [ID_W-1:0] s1_id, rr_ptr, grant, idx;
    logic [ID_W:0]   probe;

    assign fpa_sum = fpa(s1_a, s1_b);
    assign busy    = s1_valid | resp_valid;

    // Descending scan so the requester closest to rr_ptr wins the grant.
    always_comb begin
        s2_load     = s1_valid & (~resp_valid | resp_ready);
        s1_load     = ~s1_valid | s2_load;
        grant_found = 1'b0;
        grant       = '0;
        probe       = '0;
        idx         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            probe = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (probe >= NUM_REQ_W) probe = probe - NUM_REQ_W;
            idx = probe[ID_W-1:0];
            if (req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
        req_ready = '0;
        if (rst_n && s1_load && grant_found) req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_id      <= '0;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            op_count   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= grant_found;
                if (grant_found) begin
                    s1_a   <= req_a[{grant, 5'b00000} +: 32];
                    s1_b   <= req_b[{grant, 5'b00000} +: 32];
                    s1_id  <= grant;
                    rr_ptr <= (grant == LAST_ID) ? '0 : grant + 1'b1;
                end
            end
            if (s2_load) begin
                resp_valid <= 1'b1;
                resp_data  <= fpa_sum;
                resp_id    <= s1_id;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
            if (resp_valid && resp_ready) op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fpa_arbiter.sv
// Self-checking bench for fpa_arbiter: directed scenarios plus random traffic
// against a transaction-level FIFO model of the two-deep pipeline.
module tb_fpa_arbiter;

    logic         clk, rst_n, resp_ready, resp_valid, busy;
    logic [3:0]   req_valid, req_ready, op_count;
    logic [127:0] req_a, req_b;
    logic [31:0]  resp_data;
    logic [1:0]   resp_id;

    fpa_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: ops in acceptance order, each stamped with the edge that accepted it.
    typedef struct {
        logic [1:0]  id;
        logic [31:0] d;
        int          t;
    } ent_t;
    ent_t        q[$];
    int          rr, cur_edge, resps, last_grant, n_vec, n_bad;
    logic [31:0] exp_sum[4];
    logic        e_vis, e_busy;
    logic [3:0]  e_ready;
    int          e_grant;
    logic [1:0]  e_id;
    logic [31:0] e_data;

    function automatic logic [31:0] int2f(int v);
        int          m, p;
        logic [31:0] r;
        if (v == 0) return 32'd0;
        m = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if (m >= (1 << i)) p = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
        return r;
    endfunction

    task automatic new_ops(int i);
        int x, y;
        x = int'($urandom_range(0, 2000)) - 1000;
        y = int'($urandom_range(0, 2000)) - 1000;
        req_a[i*32 +: 32] = int2f(x);
        req_b[i*32 +: 32] = int2f(y);
        exp_sum[i]        = int2f(x + y);
    endtask

    // The head result is visible once an edge has passed since its acceptance;
    // a new op fits while fewer than two are held or the head leaves this cycle.
    function automatic void calc();
        e_vis   = (q.size() > 0) && (q[0].t < cur_edge);
        e_busy  = (q.size() > 0);
        e_ready = 4'b0000;
        e_grant = -1;
        if (rst_n && (q.size() < 2 || (e_vis && resp_ready)))
            for (int k = 0; k < 4; k++)
                if (e_grant < 0 && req_valid[(rr + k) % 4]) e_grant = (rr + k) % 4;
        if (e_grant >= 0) e_ready[e_grant] = 1'b1;
        e_id   = e_vis ? q[0].id : 2'd0;
        e_data = e_vis ? q[0].d : 32'd0;
    endfunction

    task automatic tick();
        int   g;
        bit   cons;
        ent_t e;
        calc();
        g    = e_grant;
        cons = e_vis && resp_ready && rst_n;
        @(posedge clk);
        #1;
        cur_edge++;
        if (!rst_n) begin
            q.delete();
            rr = 0; resps = 0; last_grant = -1;
            return;
        end
        if (cons) begin
            void'(q.pop_front());
            resps++;
        end
        if (g >= 0) begin
            e.id = 2'(g); e.d = exp_sum[g]; e.t = cur_edge;
            q.push_back(e);
            rr = (g + 1) % 4;
        end
        last_grant = g;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'b0000;
        q.delete();
        rr = 0; resps = 0; last_grant = -1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        req_valid = 4'b1111; resp_ready = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 4'b0000 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset.outputs got ready=%b valid=%b busy=%b want 0000/0/0", req_ready, resp_valid, busy);
        end
        tick();
        n_vec++;
        if (op_count !== 4'd0 || resp_data !== 32'd0 || resp_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset.regs got cnt=%0d data=%h id=%0d want 0/0/0", op_count, resp_data, resp_id);
        end
        req_valid = 4'b0000;
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        resp_ready = 1'b1;
        req_valid  = 4'b0010;
        req_a[63:32] = 32'h3F80_0000; req_b[63:32] = 32'h4000_0000; exp_sum[1] = 32'h4040_0000;
        #1;
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_bad++; $display("FAIL single.ready got %b want 0010", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL single.s1 got valid=%b busy=%b want 0/1", resp_valid, busy);
        end
        tick();
        n_vec++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h4040_0000 || resp_id !== 2'd1) begin
            n_bad++; $display("FAIL single.resp got valid=%b data=%h id=%0d want 1/40400000/1", resp_valid, resp_data, resp_id);
        end
        tick();
        n_vec++;
        if (op_count !== 4'd1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single.count got cnt=%0d busy=%b want 1/0", op_count, busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) new_ops(i);
        req_valid = 4'b1111; resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1 calc();
            n_vec++;
            if (req_ready !== 4'(1 << (c % 4))) begin
                n_bad++; $display("FAIL rr.grant c=%0d got %b want %b", c, req_ready, 4'(1 << (c % 4)));
            end
            if (c >= 2) begin
                n_vec++;
                if (resp_valid !== 1'b1 || resp_id !== 2'((c - 2) % 4) || resp_data !== e_data) begin
                    n_bad++;
                    $display("FAIL rr.resp c=%0d got v=%b id=%0d d=%h want 1/%0d/%h", c, resp_valid, resp_id, resp_data, (c - 2) % 4, e_data);
                end
            end
            tick();
            if (last_grant >= 0) new_ops(last_grant);
        end
        req_valid = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        do_reset();
        for (int i = 0; i < 4; i++) new_ops(i);
        req_valid = 4'b1111; resp_ready = 1'b0;
        held = 32'd0;
        for (int c = 0; c < 8; c++) begin
            resp_ready = (c >= 6);
            #1 calc();
            n_vec++;
            if (req_ready !== ((c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : (c == 6) ? 4'b0100 : (c == 7) ? 4'b1000 : 4'b0000)) begin
                n_bad++; $display("FAIL bp.ready c=%0d got %b", c, req_ready);
            end
            if (c == 2) begin
                held = e_data;
                n_vec++;
                if (resp_data !== e_data) begin
                    n_bad++; $display("FAIL bp.data got %h want %h", resp_data, e_data);
                end
            end
            if (c >= 2) begin
                n_vec++;
                if (resp_valid !== 1'b1 || resp_id !== ((c == 7) ? 2'd1 : 2'd0) || (c < 7 && resp_data !== held)) begin
                    n_bad++; $display("FAIL bp.hold c=%0d got v=%b id=%0d d=%h held=%h", c, resp_valid, resp_id, resp_data, held);
                end
            end
            tick();
            if (last_grant >= 0) new_ops(last_grant);
        end
        req_valid = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            #1 calc();
            n_vec++;
            if (resp_valid !== e_vis || (e_vis && (resp_id !== e_id || resp_data !== e_data))) begin
                n_bad++; $display("FAIL bp.drain c=%0d got v=%b id=%0d want v=%b id=%0d", c, resp_valid, resp_id, e_vis, e_id);
            end
            tick();
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL bp.idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_sparse();
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b1000;
        req_a[127:96] = 32'h4020_0000; req_b[127:96] = 32'h3F00_0000; exp_sum[3] = 32'h4040_0000;
        #1;
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_bad++; $display("FAIL sparse.ready got %b want 1000", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        tick();
        n_vec++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h4040_0000 || resp_id !== 2'd3) begin
            n_bad++; $display("FAIL sparse.resp got v=%b d=%h id=%0d want 1/40400000/3", resp_valid, resp_data, resp_id);
        end
        new_ops(2);
        req_valid = 4'b0100;
        #1;
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL sparse.req2 got %b want 0100", req_ready);
        end
        tick();
        new_ops(0); new_ops(1);
        req_valid = 4'b0011;
        #1;
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_bad++; $display("FAIL sparse.wrap got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 4; i++) new_ops(i);
        req_valid = 4'b1111; resp_ready = 1'b0;
        tick(); tick();
        #1 calc();
        n_vec++;
        if (busy !== 1'b1 || resp_valid !== e_vis) begin
            n_bad++; $display("FAIL mid.full got busy=%b v=%b want 1/%b", busy, resp_valid, e_vis);
        end
        rst_n = 1'b0;
        q.delete(); rr = 0; resps = 0;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || op_count !== 4'd0) begin
            n_bad++; $display("FAIL mid.async got v=%b busy=%b ready=%b cnt=%0d want 0/0/0000/0", resp_valid, busy, req_ready, op_count);
        end
        tick();
        new_ops(1); new_ops(2);
        req_valid = 4'b0110; resp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 4'b0010 || resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid.first got ready=%b v=%b want 0010/0", req_ready, resp_valid);
        end
        tick();
        req_valid[1] = 1'b0;
        #1;
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL mid.stale got v=%b want 0", resp_valid);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        n_vec++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== exp_sum[1]) begin
            n_bad++; $display("FAIL mid.resp got v=%b id=%0d d=%h want 1/1/%h", resp_valid, resp_id, resp_data, exp_sum[1]);
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            #1 calc();
            n_vec++;
            if (req_ready !== e_ready) begin
                n_bad++; $display("FAIL rand.ready c=%0d got %b want %b", c, req_ready, e_ready);
            end
            n_vec++;
            if (resp_valid !== e_vis || busy !== e_busy || op_count !== 4'(resps)) begin
                n_bad++; $display("FAIL rand.state c=%0d got v=%b b=%b n=%0d want %b/%b/%0d", c, resp_valid, busy, op_count, e_vis, e_busy, resps % 16);
            end
            if (e_vis) begin
                n_vec++;
                if (resp_data !== e_data || resp_id !== e_id) begin
                    n_bad++; $display("FAIL rand.resp c=%0d got %0d:%h want %0d:%h", c, resp_id, resp_data, e_id, e_data);
                end
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                if (last_grant == i) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    if (req_valid[i]) new_ops(i);
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    new_ops(i);
                end
            end
        end
        req_valid = 4'b0000; resp_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_counter_wrap();
        int prev, cycles;
        do_reset();
        new_ops(0);
        req_valid = 4'b0001; resp_ready = 1'b1;
        cycles = 0;
        while (resps < 17 && cycles < 40) begin
            prev = resps;
            tick();
            cycles++;
            if (last_grant == 0) new_ops(0);
            if (resps != prev) begin
                n_vec++;
                if (op_count !== 4'(resps % 16)) begin
                    n_bad++; $display("FAIL wrap.count after %0d got %0d want %0d", resps, op_count, resps % 16);
                end
            end
        end
        n_vec++;
        if (resps != 17 || op_count !== 4'd1) begin
            n_bad++; $display("FAIL wrap.final got handshakes=%0d cnt=%0d want 17/1", resps, op_count);
        end
        req_valid = 4'b0000;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired, got no finish want finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        n_vec = 0; n_bad = 0; cur_edge = 0; rr = 0; resps = 0; last_grant = -1;
        rst_n = 1'b0; req_valid = 4'b0000; resp_ready = 1'b0;
        req_a = '0; req_b = '0;
        for (int i = 0; i < 4; i++) exp_sum[i] = 32'd0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_back_to_back();
        test_sparse();
        test_reset_midflight();
        test_random();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
